// File: rtl/dma_sequencer.sv
// dma_sequencer: steps multi-beat 64-bit DMA transfers between DBUS and IMEM/DMEM,
// driving the bus-interface DMA controls and tracking read returns through a delay line.
`default_nettype none

module dma_sequencer #(
   parameter int LEN_W    = 9,
   parameter int RD_LAT_D = 2,
   parameter int RD_LAT_I = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             dir,
   input  logic             imem_sel,
   input  logic [8:0]       base_addr,
   input  logic [LEN_W-1:0] beat_count,
   input  logic [1:0]       first_mask,
   input  logic [1:0]       last_mask,
   input  logic             abort,
   input  logic             dbus_valid,
   output logic [8:0]       dma_address,
   output logic [1:0]       dma_mask,
   output logic             dma_imem_select,
   output logic             dma_dm_to_rd,
   output logic             dma_rd_to_dm,
   output logic             dbus_read_enable,
   output logic             dbus_write_enable,
   output logic             imem_dma_cycle,
   output logic             fetch_stall,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_ISSUE = 3'd1,
      S_WR_WAIT  = 3'd2,
      S_WR_ISSUE = 3'd3,
      S_DRAIN    = 3'd4,
      S_FIN      = 3'd5
   } state_t;

   // Read tokens enter the delay line at a latency-dependent tap and all leave from the top bit,
   // so an empty line is simply all-zero for either target.
   localparam logic [RD_LAT_I-1:0] INS_I = RD_LAT_I'(1);
   localparam logic [RD_LAT_I-1:0] INS_D = INS_I << (RD_LAT_I - RD_LAT_D);

   state_t             state_q;
   logic [8:0]         addr_q;
   logic [LEN_W-1:0]   rem_q;
   logic               first_q;
   logic               imem_q;
   logic [1:0]         fmask_q;
   logic [1:0]         lmask_q;
   logic [RD_LAT_I-1:0] pipe_q;
   logic               hold_q;
   logic               imem_cyc_q;
   logic               aborted_q;

   logic       rd_issue;
   logic       wr_issue;
   logic       issue;
   logic       active;
   logic       last_beat;
   logic       wr_capture;
   logic       pipe_near_empty;
   logic [1:0] beat_mask;

   assign rd_issue        = (state_q == S_RD_ISSUE);
   assign wr_issue        = (state_q == S_WR_ISSUE);
   assign issue           = rd_issue | wr_issue;
   assign active          = issue | (state_q == S_WR_WAIT);
   assign last_beat       = (rem_q == '0);
   assign pipe_near_empty = (pipe_q[RD_LAT_I-2:0] == '0);
   assign wr_capture      = dbus_valid & ~abort &
                            ((state_q == S_WR_WAIT) | (wr_issue & ~last_beat));

   always_comb begin
      beat_mask = 2'b11;
      if (first_q && last_beat) beat_mask = fmask_q & lmask_q;
      else if (first_q)         beat_mask = fmask_q;
      else if (last_beat)       beat_mask = lmask_q;
   end

   assign busy              = (state_q != S_IDLE);
   assign done              = (state_q == S_FIN);
   assign dma_address       = busy ? addr_q : 9'd0;
   assign dma_mask          = issue ? beat_mask : 2'b00;
   assign dma_imem_select   = busy & imem_q;
   assign fetch_stall       = busy & imem_q;
   assign dma_dm_to_rd      = rd_issue;
   assign dma_rd_to_dm      = wr_issue;
   assign dbus_read_enable  = wr_capture;
   assign dbus_write_enable = pipe_q[RD_LAT_I-1];
   assign imem_dma_cycle    = imem_cyc_q;
   assign aborted           = aborted_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         first_q    <= 1'b0;
         imem_q     <= 1'b0;
         fmask_q    <= '0;
         lmask_q    <= '0;
         pipe_q     <= '0;
         hold_q     <= 1'b0;
         imem_cyc_q <= 1'b0;
         aborted_q  <= 1'b0;
      end else begin
         pipe_q     <= {pipe_q[RD_LAT_I-2:0], 1'b0} | (rd_issue ? (imem_q ? INS_I : INS_D) : '0);
         imem_cyc_q <= issue & imem_q;
         if (issue) begin
            addr_q  <= addr_q + 9'd1;
            rem_q   <= rem_q - LEN_W'(1);
            first_q <= 1'b0;
         end
         if (active && abort) aborted_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  addr_q    <= base_addr;
                  rem_q     <= beat_count;
                  first_q   <= 1'b1;
                  imem_q    <= imem_sel;
                  fmask_q   <= first_mask;
                  lmask_q   <= last_mask;
                  aborted_q <= 1'b0;
                  state_q   <= dir ? S_WR_WAIT : S_RD_ISSUE;
               end
            end
            S_RD_ISSUE: begin
               if (abort || last_beat) state_q <= S_DRAIN;
            end
            S_WR_WAIT: begin
               if (abort)           state_q <= S_DRAIN;
               else if (dbus_valid) state_q <= S_WR_ISSUE;
            end
            S_WR_ISSUE: begin
               if (abort || last_beat) begin
                  state_q <= S_DRAIN;
                  // IMEM writes commit two cycles after issue; one extra drain cycle covers it.
                  hold_q  <= imem_q;
               end else if (dbus_valid) begin
                  state_q <= S_WR_ISSUE;
               end else begin
                  state_q <= S_WR_WAIT;
               end
            end
            S_DRAIN: begin
               if (hold_q)               hold_q  <= 1'b0;
               else if (pipe_near_empty) state_q <= S_FIN;
            end
            S_FIN:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dma_sequencer.sv
// tb_dma_sequencer: directed and randomized transfers checked cycle by cycle against an
// event-list model of issues, returns, captures and completion timing.
`default_nettype none

module tb_dma_sequencer;

   localparam int LEN_W = 9;
   localparam int LAT_D = 2;
   localparam int LAT_I = 4;
   localparam int MAXC  = 160;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, dir, imem_sel, abort, dbus_valid;
   logic [8:0]       base_addr;
   logic [LEN_W-1:0] beat_count;
   logic [1:0]       first_mask, last_mask;
   logic [8:0]       dma_address;
   logic [1:0]       dma_mask;
   logic dma_imem_select, dma_dm_to_rd, dma_rd_to_dm, dbus_read_enable, dbus_write_enable;
   logic imem_dma_cycle, fetch_stall, busy, done, aborted;

   dma_sequencer #(.LEN_W(LEN_W), .RD_LAT_D(LAT_D), .RD_LAT_I(LAT_I)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .imem_sel(imem_sel),
      .base_addr(base_addr), .beat_count(beat_count), .first_mask(first_mask),
      .last_mask(last_mask), .abort(abort), .dbus_valid(dbus_valid),
      .dma_address(dma_address), .dma_mask(dma_mask), .dma_imem_select(dma_imem_select),
      .dma_dm_to_rd(dma_dm_to_rd), .dma_rd_to_dm(dma_rd_to_dm),
      .dbus_read_enable(dbus_read_enable), .dbus_write_enable(dbus_write_enable),
      .imem_dma_cycle(imem_dma_cycle), .fetch_stall(fetch_stall), .busy(busy),
      .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transaction description
   bit         t_dir, t_imem;
   bit [8:0]   t_base;
   int         t_cnt;
   bit [1:0]   t_fm, t_lm;
   int         t_ab, t_sb;
   bit         vld [MAXC];
   bit         prev_ab;

   // Expected per-cycle behaviour (cycle 0 = start cycle)
   bit         e_rd [MAXC], e_wr [MAXC], e_we [MAXC], e_re [MAXC], e_icyc [MAXC];
   bit [8:0]   e_addr [MAXC];
   bit [1:0]   e_mask [MAXC];
   int         e_done;
   bit         e_ab;

   function automatic bit [1:0] mask_of(input int i, input int n);
      if (n == 1)     return t_fm & t_lm;
      if (i == 0)     return t_fm;
      if (i == n - 1) return t_lm;
      return 2'b11;
   endfunction

   task automatic model();
      int n, k, lat, cap, last_iss, e;
      n   = t_cnt + 1;
      lat = t_imem ? LAT_I : LAT_D;
      for (int c = 0; c < MAXC; c++) begin
         e_rd[c] = 0; e_wr[c] = 0; e_we[c] = 0; e_re[c] = 0; e_icyc[c] = 0;
         e_addr[c] = 0; e_mask[c] = 0;
      end
      e_ab = 0;
      if (!t_dir) begin
         k = n;
         if (t_ab >= 1 && t_ab <= n) begin k = t_ab; e_ab = 1; end
         for (int i = 0; i < k; i++) begin
            e_rd[1+i]   = 1;
            e_addr[1+i] = t_base + 9'(i);
            e_mask[1+i] = mask_of(i, n);
            e_we[1+i+lat] = 1;
            if (t_imem) e_icyc[2+i] = 1;
         end
         e_done = k + lat + 1;
      end else begin
         cap = 0; last_iss = 0;
         for (int c = 1; c < MAXC - 12 && cap < n; c++) begin
            if (t_ab != 0 && c >= t_ab) break;
            if (vld[c]) begin
               e_re[c]     = 1;
               e_wr[c+1]   = 1;
               e_addr[c+1] = t_base + 9'(cap);
               e_mask[c+1] = mask_of(cap, n);
               if (t_imem) e_icyc[c+2] = 1;
               cap++;
               last_iss = c + 1;
            end
         end
         if (cap == n) begin
            e = last_iss;
            e_ab = (t_ab >= 1 && t_ab <= e);
         end else begin
            e = t_ab;
            e_ab = 1;
         end
         e_done = e + 2 + ((t_imem && last_iss == e) ? 1 : 0);
      end
   endtask

   task automatic set_tx(input bit d, input bit im, input bit [8:0] b, input int cnt,
                         input bit [1:0] fm, input bit [1:0] lm, input int ab, input int sb);
      t_dir = d; t_imem = im; t_base = b; t_cnt = cnt; t_fm = fm; t_lm = lm;
      t_ab = ab; t_sb = sb;
      for (int c = 0; c < MAXC; c++) vld[c] = (c > 40) ? 1'b1 : 1'($urandom_range(0, 1));
   endtask

   task automatic drive_params();
      dir = t_dir; imem_sel = t_imem; base_addr = t_base; beat_count = LEN_W'(t_cnt);
      first_mask = t_fm; last_mask = t_lm;
   endtask

   task automatic run_tx();
      bit busy_e, iss;
      model();
      if (t_sb < 0) t_sb = 1 + int'($urandom_range(0, e_done - 1));
      for (int c = 0; c <= e_done + 3; c++) begin
         @(negedge clk);
         if (c == t_sb && t_sb != 0) begin
            dir = ~t_dir; imem_sel = ~t_imem; base_addr = 9'($urandom);
            beat_count = LEN_W'($urandom_range(0, 7));
            first_mask = 2'($urandom); last_mask = 2'($urandom);
         end else begin
            drive_params();
         end
         start      = (c == 0) || (c == t_sb && t_sb != 0);
         dbus_valid = vld[c];
         abort      = (t_ab != 0 && c == t_ab);
         #1;
         busy_e = (c >= 1 && c <= e_done);
         iss    = e_rd[c] | e_wr[c];
         chk($sformatf("rd_strobe@%0d", c), dma_dm_to_rd, e_rd[c]);
         chk($sformatf("wr_strobe@%0d", c), dma_rd_to_dm, e_wr[c]);
         chk($sformatf("mask@%0d", c), dma_mask, e_mask[c]);
         if (iss || !busy_e) chk($sformatf("addr@%0d", c), dma_address, e_addr[c]);
         chk($sformatf("dbus_we@%0d", c), dbus_write_enable, e_we[c]);
         chk($sformatf("dbus_re@%0d", c), dbus_read_enable, e_re[c]);
         chk($sformatf("done@%0d", c), done, (c == e_done));
         chk($sformatf("busy@%0d", c), busy, busy_e);
         chk($sformatf("imem_cyc@%0d", c), imem_dma_cycle, e_icyc[c]);
         chk($sformatf("stall@%0d", c), fetch_stall, busy_e & t_imem);
         chk($sformatf("imem_sel@%0d", c), dma_imem_select, busy_e & t_imem);
         chk($sformatf("aborted@%0d", c), aborted,
             (c == 0) ? prev_ab : (e_ab && c > t_ab));
      end
      start = 0; abort = 0; dbus_valid = 0;
      prev_ab = e_ab;
   endtask

   task automatic rand_tx();
      set_tx(1'($urandom), 1'($urandom), 9'($urandom), int'($urandom_range(0, 12)),
             2'($urandom), 2'($urandom),
             ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0,
             ($urandom_range(0, 1) == 0) ? -1 : 0);
      run_tx();
   endtask

   initial begin
      rst_n = 0; start = 0; abort = 0; dbus_valid = 0;
      dir = 0; imem_sel = 0; base_addr = 0; beat_count = 0; first_mask = 0; last_mask = 0;
      prev_ab = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", dma_address, 0);
      chk("rst_we", dbus_write_enable, 0);
      chk("rst_aborted", aborted, 0);
      @(negedge clk) rst_n = 1;

      // DMEM read 0x1F0..0x1F3
      set_tx(0, 0, 9'h1F0, 3, 2'b11, 2'b11, 0, 0); run_tx();
      // IMEM read with address wrap
      set_tx(0, 1, 9'h1FF, 1, 2'b11, 2'b11, 0, 0); run_tx();
      // DMEM write with gapped dbus_valid 1,0,1,1
      set_tx(1, 0, 9'h040, 2, 2'b10, 2'b01, 0, 0);
      vld[1] = 1; vld[2] = 0; vld[3] = 1; vld[4] = 1;
      run_tx();
      // Single-beat write, plus a start while busy
      set_tx(1, 0, 9'h011, 0, 2'b11, 2'b01, 0, 2);
      vld[1] = 1;
      run_tx();
      // Abort on the third issue of an 8-beat read, then a clean transfer clears aborted
      set_tx(0, 0, 9'h100, 7, 2'b01, 2'b10, 3, 0); run_tx();
      set_tx(0, 1, 9'h0A0, 2, 2'b11, 2'b11, 0, 0); run_tx();

      // Reset in the middle of a read
      set_tx(0, 0, 9'h020, 7, 2'b11, 2'b11, 0, 0);
      @(negedge clk); drive_params(); start = 1;
      @(negedge clk); start = 0;
      repeat (3) @(negedge clk);
      rst_n = 0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_rd", dma_dm_to_rd, 0);
      chk("midrst_addr", dma_address, 0);
      chk("midrst_mask", dma_mask, 0);
      chk("midrst_we", dbus_write_enable, 0);
      chk("midrst_stall", fetch_stall, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk($sformatf("midrst_done%0d", i), done, 0);
      end
      @(negedge clk) rst_n = 1;
      prev_ab = 0;
      set_tx(1, 1, 9'h1FE, 3, 2'b01, 2'b11, 0, 0); run_tx();

      for (int i = 0; i < 30; i++) rand_tx();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
